// File: rtl/f5_check_seq.sv
// Clocked start/done sequencer that sweeps the f5 minterms, captures both truth tables and counts mismatches.
// Define F5_SEQ_GOLDEN_EN to also compare the gate-level output against an internal golden ~a & b.
module f5_check_seq #(
    parameter int SETTLE = 1,
    parameter int PASSES = 1,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          a_out,
    output logic          b_out,
    input  logic          sa_in,
    input  logic          sb_in,
    output logic          busy,
    output logic          done,
    output logic [3:0]    tt_a,
    output logic [3:0]    tt_b,
    output logic [CW-1:0] mism_cnt,
    output logic          pass_ok
);
    // state  | meaning
    // IDLE   | waiting for start, results held
    // DRIVE  | holding minterm m on a_out/b_out for SETTLE cycles
    // SAMPLE | capturing sa_in/sb_in for minterm m, stepping m/pass
    // DONE   | one-cycle done pulse, pass_ok updated
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_t        r_state, w_next;
    logic [1:0]    r_m;
    logic [SW-1:0] r_settle;
    logic [PW-1:0] r_pass;
    logic          r_busy, r_done, r_pass_ok;
    logic [3:0]    r_tt_a, r_tt_b;
    logic [CW-1:0] r_mism;
    logic          w_settle_tc, w_last_m, w_last_pass, w_mism;

    assign w_settle_tc = (r_settle == SW'(SETTLE - 1));
    assign w_last_m    = (r_m == 2'd3);
    assign w_last_pass = (r_pass == PW'(PASSES - 1));

`ifdef F5_SEQ_GOLDEN_EN
    logic w_golden;
    assign w_golden = ~r_m[1] & r_m[0];
    assign w_mism   = (sa_in != sb_in) || (sa_in != w_golden);
`else
    assign w_mism   = (sa_in != sb_in);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRIVE;
            DRIVE:   if (w_settle_tc) w_next = SAMPLE;
            SAMPLE:  w_next = (w_last_m && w_last_pass) ? DONE : DRIVE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_m       <= 2'd0;
            r_settle  <= '0;
            r_pass    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass_ok <= 1'b0;
            r_tt_a    <= 4'd0;
            r_tt_b    <= 4'd0;
            r_mism    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m       <= 2'd0;
                        r_settle  <= '0;
                        r_pass    <= '0;
                        r_tt_a    <= 4'd0;
                        r_tt_b    <= 4'd0;
                        r_mism    <= '0;
                        r_pass_ok <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!w_settle_tc) r_settle <= r_settle + 1'b1;
                end
                SAMPLE: begin
                    r_tt_a[r_m] <= sa_in;
                    r_tt_b[r_m] <= sb_in;
                    // saturate rather than wrap so a long faulty run never reads as clean
                    if (w_mism && (r_mism != '1)) r_mism <= r_mism + 1'b1;
                    r_settle <= '0;
                    if (!w_last_m) begin
                        r_m <= r_m + 2'd1;
                    end else if (!w_last_pass) begin
                        r_m    <= 2'd0;
                        r_pass <= r_pass + 1'b1;
                    end
                end
                DONE: begin
                    r_pass_ok <= (r_mism == '0);
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign a_out    = r_m[1];
    assign b_out    = r_m[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign tt_a     = r_tt_a;
    assign tt_b     = r_tt_b;
    assign mism_cnt = r_mism;
    assign pass_ok  = r_pass_ok;
endmodule
